bcd_addsub_serial: RTL and testbench

Parametrised, digit-serial packed-BCD adder/subtractor for DIGITS-wide decimal operands. It processes one BCD digit per clock through a single corrected digit adder. In subtract mode it returns sign and magnitude: a negative difference is recomplemented in a second serial pass. It sits behind a valid/ready request port and presents results on a valid/ready response port, as the multi-digit arithmetic unit of the decimal datapath.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adder.sv | 25 ++
 rtl/bcd_addsub_serial.sv | 148 ++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD add/subtract unit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - combinational single-digit decimal adder with >9 correction
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] digit,
  output logic       c_out
);

  logic [4:0] s;

  always_comb begin
    s = {1'b0, x} + {1'b0, y} + {4'b0, c_in};
    if (s > 5'd9) begin
      digit = s[3:0] + BCD_CORR;
      c_out = 1'b1;
    end else begin
      digit = s[3:0];
      c_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial packed-BCD adder/subtractor, sign-magnitude subtract
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                mode,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  state_t         state, state_nxt;
  logic [W-1:0]   a_sr, b_sr, r_sr;
  logic [CW-1:0]  cnt;
  logic           mode_r, carry, err_r, cout_r, neg_r;
  logic           accept, last, in_bad;
  logic [3:0]     add_x, add_y, add_digit;
  logic           add_cout;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(DIGITS - 1));

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(a[4*i +: 4]) || !digit_ok(b[4*i +: 4])) in_bad = 1'b1;
    end
  end

  bcd_digit_adder u_digit_adder (
    .x     (add_x),
    .y     (add_y),
    .c_in  (carry),
    .digit (add_digit),
    .c_out (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD: begin
        if (err_r)     state_nxt = DONE;
        else if (last) state_nxt = (mode_r && !add_cout) ? RECOMP : DONE;
      end
      RECOMP:  if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The shared adder sees operand digits in ADD and the nines-complement of R in RECOMP.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    add_x     = 4'd0;
    add_y     = 4'd0;
    case (state)
      ADD: begin
        add_x = a_sr[3:0];
        add_y = mode_r ? (BCD_NINE - b_sr[3:0]) : b_sr[3:0];
      end
      RECOMP:  add_x = BCD_NINE - r_sr[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      err_r  <= 1'b0;
      cout_r <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            r_sr   <= '0;
            cnt    <= '0;
            mode_r <= mode;
            carry  <= mode ? ~cin : cin;
            err_r  <= in_bad;
            cout_r <= 1'b0;
            neg_r  <= 1'b0;
          end
        end
        ADD: begin
          if (!err_r) begin
            a_sr  <= a_sr >> 4;
            b_sr  <= b_sr >> 4;
            r_sr  <= (r_sr >> 4) | (W'(add_digit) << (W - 4));
            cnt   <= cnt + 1'b1;
            carry <= add_cout;
            if (last) begin
              cnt <= '0;
              if (!mode_r) begin
                cout_r <= add_cout;
              end else if (!add_cout) begin
                // No carry out of the tens-complement sum means A-B-cin went negative.
                cout_r <= 1'b1;
                neg_r  <= 1'b1;
                carry  <= 1'b1;
              end
            end
          end
        end
        RECOMP: begin
          r_sr  <= (r_sr >> 4) | (W'(add_digit) << (W - 4));
          cnt   <= cnt + 1'b1;
          carry <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign result = r_sr;
  assign cout   = cout_r;
  assign neg    = neg_r;
  assign err    = err_r;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - directed self-checking bench for bcd_addsub_serial
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        mode, cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout, neg, err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_addsub_serial #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .neg       (neg),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall, then complete the handshake.
  // in_valid stays high with junk operands while busy; none of it may be accepted.
  task automatic run(input string tag, input logic [15:0] av, input logic [15:0] bv,
                     input logic m, input logic c, input logic [15:0] exp_r,
                     input logic exp_c, input logic exp_n, input logic exp_e,
                     input int exp_lat, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    a = av; b = bv; mode = m; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'hF9F9; b = 16'h9F9F; mode = ~m; cin = ~c;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, {16'd0, result}, {16'd0, exp_r});
    check({tag, " flags"}, {29'd0, cout, neg, err}, {29'd0, exp_c, exp_n, exp_e});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {15'd0, out_valid, in_ready, cout, neg, err, result},
            {15'd0, 1'b1, 1'b0, exp_c, exp_n, exp_e, exp_r});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {31'd0, in_ready}, 32'd0);
    check("reset outs", {12'd0, out_valid, cout, neg, err, result}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready after reset", {31'd0, in_ready}, 32'd1);

    run("add",      16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 4, 0);
    run("add ovf",  16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 0);
    run("sub pos",  16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 4, 0);
    run("sub neg",  16'h0123, 16'h0456, 1'b1, 1'b0, 16'h0333, 1'b1, 1'b1, 1'b0, 8, 0);
    run("sub zero", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 8, 0);
    run("sub eq",   16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 0);
    run("add cin",  16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 4, 0);
    run("err",      16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0);
    run("after err",16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 0);
    run("stall",    16'h2500, 16'h7500, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 3);

    // Abort mid-ADD with reset.
    a = 16'h1111; b = 16'h2222; mode = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready in rst", {31'd0, in_ready}, 32'd0);
    check("abort cleared", {15'd0, out_valid, result}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort ready after", {31'd0, in_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort no out_valid", seen, 0);
    end

    run("post abort", 16'h0045, 16'h0055, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
